// File: rtl/iotdf_pkg.sv
// Shared definitions for the parametrised IoT data filter: function codes and a
// width helper used to size the round sum.
package iotdf_pkg;

  localparam logic [2:0] FN_PASS    = 3'd0;
  localparam logic [2:0] FN_MAX     = 3'd1;
  localparam logic [2:0] FN_MIN     = 3'd2;
  localparam logic [2:0] FN_AVG     = 3'd3;
  localparam logic [2:0] FN_EXTRACT = 3'd4;
  localparam logic [2:0] FN_EXCLUDE = 3'd5;
  localparam logic [2:0] FN_PEAKMAX = 3'd6;
  localparam logic [2:0] FN_PEAKMIN = 3'd7;

  // Ceiling log2, at least 1 so it can size a counter directly.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iotdf_deser.sv
// Beat deserialiser: shifts IN_W-bit beats MSB-first into a DATA_W-bit word and
// raises word_done (also the busy stall) for the cycle after the last beat.
module iotdf_deser
  import iotdf_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned IN_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_en,
  input  logic [IN_W-1:0]   iot_in,
  output logic              busy,
  output logic              first_beat,
  output logic              word_done,
  output logic [DATA_W-1:0] word
);

  localparam int unsigned NBEATS = DATA_W / IN_W;
  localparam int unsigned CNT_W  = clog2(NBEATS);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              done_q, done_d;
  logic              accept, last_beat;

  assign accept    = in_en & ~done_q;
  assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    if (accept) begin
      cnt_d   = last_beat ? '0 : cnt_q + CNT_W'(1);
      shreg_d = (shreg_q << IN_W) | DATA_W'(iot_in);
      done_d  = last_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  assign busy       = done_q;
  assign word_done  = done_q;
  assign first_beat = accept & (cnt_q == '0);
  assign word       = shreg_q;

endmodule

// File: rtl/iotdf_gen.sv
// Parametrised IoT data filter: groups deserialised words into rounds of GRP and
// applies one of eight runtime-selected functions, strobing results on valid.
module iotdf_gen
  import iotdf_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned IN_W   = 8,
  parameter int unsigned GRP    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_en,
  input  logic [IN_W-1:0]   iot_in,
  input  logic [2:0]        fn_sel,
  input  logic [DATA_W-1:0] thr_lo,
  input  logic [DATA_W-1:0] thr_hi,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] iot_out
);

  localparam int unsigned LG    = clog2(GRP);
  localparam int unsigned SUM_W = DATA_W + LG;

  logic              first_beat, word_done;
  logic [DATA_W-1:0] w;

  iotdf_deser #(
    .DATA_W (DATA_W),
    .IN_W   (IN_W)
  ) u_deser (
    .clk        (clk),
    .rst        (rst),
    .in_en      (in_en),
    .iot_in     (iot_in),
    .busy       (busy),
    .first_beat (first_beat),
    .word_done  (word_done),
    .word       (w)
  );

  logic [2:0]        fn_q;
  logic [DATA_W-1:0] lo_q, hi_q;
  logic [LG-1:0]     rnd_q;
  logic [DATA_W-1:0] max_q, min_q, pk_q;
  logic [SUM_W-1:0]  sum_q;
  logic              pk_vld_q;
  logic              valid_q;
  logic [DATA_W-1:0] out_q;

  logic              rnd_first, rnd_last, round_start;
  logic [DATA_W-1:0] max_n, min_n, avg, res;
  logic [SUM_W-1:0]  sum_n, sum_sh;
  logic              emit, pk_upd;

  assign rnd_first   = (rnd_q == '0);
  assign rnd_last    = (rnd_q == LG'(GRP - 1));
  // Controls are latched only on the first beat of a round.
  assign round_start = first_beat & rnd_first;

  always_comb begin
    max_n  = rnd_first ? w : ((w > max_q) ? w : max_q);
    min_n  = rnd_first ? w : ((w < min_q) ? w : min_q);
    sum_n  = rnd_first ? SUM_W'(w) : sum_q + SUM_W'(w);
    sum_sh = sum_n >> LG;
    avg    = sum_sh[DATA_W-1:0];
    emit   = 1'b0;
    pk_upd = 1'b0;
    res    = w;
    unique case (fn_q)
      FN_PASS: emit = 1'b1;
      FN_MAX: begin
        emit = rnd_last;
        res  = max_n;
      end
      FN_MIN: begin
        emit = rnd_last;
        res  = min_n;
      end
      FN_AVG: begin
        emit = rnd_last;
        res  = avg;
      end
      // An empty or inverted range never matches, so no special case is needed.
      FN_EXTRACT: emit = (lo_q < w) && (w < hi_q);
      FN_EXCLUDE: emit = (w < lo_q) || (w > hi_q);
      FN_PEAKMAX: begin
        res    = max_n;
        pk_upd = rnd_last && (!pk_vld_q || (max_n > pk_q));
        emit   = pk_upd;
      end
      FN_PEAKMIN: begin
        res    = min_n;
        pk_upd = rnd_last && (!pk_vld_q || (min_n < pk_q));
        emit   = pk_upd;
      end
      default: emit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fn_q     <= FN_PASS;
      lo_q     <= '0;
      hi_q     <= '0;
      rnd_q    <= '0;
      max_q    <= '0;
      min_q    <= '0;
      sum_q    <= '0;
      pk_q     <= '0;
      pk_vld_q <= 1'b0;
      valid_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      if (round_start) begin
        fn_q <= fn_sel;
        lo_q <= thr_lo;
        hi_q <= thr_hi;
        if (fn_sel != fn_q) pk_vld_q <= 1'b0;
      end
      if (word_done) begin
        rnd_q <= rnd_last ? '0 : rnd_q + LG'(1);
        max_q <= max_n;
        min_q <= min_n;
        sum_q <= sum_n;
        if (emit) begin
          valid_q <= 1'b1;
          out_q   <= res;
        end
        if (pk_upd) begin
          pk_q     <= res;
          pk_vld_q <= 1'b1;
        end
      end
    end
  end

  assign valid   = valid_q;
  assign iot_out = out_q;

endmodule
